rgb_to_gray_stream: RTL and testbench
=====================================

Name: rgb_to_gray_stream

Overview:
Streaming RGB-to-grayscale converter that feeds the Gaussian blur stage. It takes the raw pixel stream (24-bit RGB plus frame framing flags), computes BT.601 luma in a 2-stage pipeline, and re-emits the same framing on an 8-bit grayscale stream. A frame-tracking FSM forwards only pixels that belong to a properly started frame and records framing violations. This guarantees that the Gaussian stage never sees orphan pixels.

Parameters:
FRAME_WIDTH, 640, active pixels per line; must be >= 3.
FRAME_HEIGHT, 480, active lines per frame; must be >= 3.
PIX_WIDTH, 24, input pixel width; red[23:16], green[15:8], blue[7:0]; output width is PIX_WIDTH/3.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; synchronous, active-high (asserted = 1), despite the _n suffix.
pix_val  in  1  input pixel valid; no backpressure.
pix_sof  in  1  start of frame; qualified by pix_val.
pix_eof  in  1  end of frame; qualified by pix_val.
pix_sol  in  1  start of line; qualified by pix_val.
pix_eol  in  1  end of line; qualified by pix_val.
pix_data  in  PIX_WIDTH  RGB pixel.
gray_val  out  1  output pixel valid.
gray_sof  out  1  output start of frame.
gray_eof  out  1  output end of frame.
gray_sol  out  1  output start of line.
gray_eol  out  1  output end of line.
gray_data  out  PIX_WIDTH/3  grayscale value.
frame_done  out  1  one-cycle pulse, coincident with the gray_eof beat.
err_clr  in  1  clears err_status (synchronous).
err_status  out  3  sticky errors: [0] line length, [1] frame end, [2] sof mid-frame.

Behaviour:
- Reset (rst_n = 1 at a clock edge):
  - All outputs, pipeline registers, counters and err_status go to 0; FSM goes to IDLE.
  - Applies mid-frame too: in-flight pixels are discarded and the next frame must begin with sof.
- Arithmetic:
  - Stage 1 registers pr = 77*R, pg = 150*G, pb = 29*B (16 bits each).
  - Stage 2 registers gray_data = (pr + pg + pb + 128) >> 8, using a 17-bit sum.
  - Maximum result is 255, so no saturation is needed.
- Latency:
  - Exactly 2 cycles from an accepted input beat to its gray_val beat.
  - Framing flags travel alongside the data in the pipeline.
  - Back-to-back input yields back-to-back output.
- When gray_val = 0, all gray_* flags are 0 and gray_data holds its last value.
- FSM state IDLE:
  - Beat with pix_val & pix_sof: forwarded; x = 1, y = 0; go to ACTIVE.
  - Beat with pix_val & !pix_sof: dropped (no output, no error).
- FSM state ACTIVE (all beats forwarded):
  - Each beat increments x.
  - A beat with pix_eol requires x == FRAME_WIDTH-1 before the increment; otherwise set err_status[0]. After an eol beat, x = 0 and y is incremented.
  - A beat without eol at x == FRAME_WIDTH-1: set err_status[0]; x saturates at FRAME_WIDTH-1.
  - A beat with pix_eof requires x == FRAME_WIDTH-1 and y == FRAME_HEIGHT-1; otherwise set err_status[1]. In both cases, go to IDLE and generate frame_done when that beat exits the pipeline.
  - A beat with pix_sof: set err_status[2]; forward the beat as a new frame start (x = 1, y = 0); stay in ACTIVE.
  - pix_sof and pix_eof in the same beat: eof takes priority; go to IDLE; set err_status[2].
- pix_sol is forwarded but not checked.
- err_status bits are sticky until err_clr. If err_clr and a new error occur in the same cycle, the new error wins.

Optional Feature:
Macro RGB2GRAY_FRAMING_REGEN_EN.
- Defined: gray_sof, gray_sol, gray_eol and gray_eof are regenerated from the internal counters (sof = first pixel, sol = x == 0, eol = x == FRAME_WIDTH-1, eof = last pixel of the frame). Input flags are then used only for FSM transitions and error detection, so the output always carries well-formed framing.
- Not defined: the output flags are the input flags delayed by 2 cycles. The regeneration logic is absent.

Test Plan:
- Single pixels after reset, each sent with sof:
  - RGB 0xFFFFFF -> gray_data 255.
  - 0xFF0000 -> 77.
  - 0x00FF00 -> 149.
  - 0x0000FF -> 29.
  - 0x646464 -> 100.
  - Each gray_val appears 2 cycles after its pix_val.
- Well-formed frame with W=4, H=3, continuous pix_val:
  - Required: 12 output beats, with gray_sof on beat 0, gray_eol on beats 3/7/11, gray_eof and frame_done on beat 11.
  - err_status stays 0.
- 5 pix_val beats with no sof while in IDLE, followed by a valid frame: first 5 beats produce no gray_val; frame output as above; err_status = 0.
- Line error with W=4: eol arrives on the 3rd pixel -> err_status[0] = 1 and is held. After err_clr it returns to 0.
- Framing violations:
  - sof in the middle of line 1 -> err_status[2] = 1; that beat is output with gray_sof = 1.
  - eof at (x=2, y=1) -> err_status[1] = 1; FSM returns to IDLE; frame_done pulses.
- Reset asserted 1 cycle after a valid beat: no gray_val for that beat; all outputs are 0 the next cycle.

Source files
------------

// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB-to-gray converter with frame-tracking FSM and sticky framing errors.
// Optional: define RGB2GRAY_FRAMING_REGEN_EN to rebuild output framing from the pixel counters.
module rgb_to_gray_stream #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIX_WIDTH    = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_val,
    input  logic                   pix_sof,
    input  logic                   pix_eof,
    input  logic                   pix_sol,
    input  logic                   pix_eol,
    input  logic [PIX_WIDTH-1:0]   pix_data,
    output logic                   gray_val,
    output logic                   gray_sof,
    output logic                   gray_eof,
    output logic                   gray_sol,
    output logic                   gray_eol,
    output logic [PIX_WIDTH/3-1:0] gray_data,
    output logic                   frame_done,
    input  logic                   err_clr,
    output logic [2:0]             err_status
);
    localparam int CW     = PIX_WIDTH / 3;
    localparam int PW     = 2 * CW;
    localparam int XW     = $clog2(FRAME_WIDTH);
    localparam int YW     = $clog2(FRAME_HEIGHT) + 1;
    localparam int STAGES = 2;

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
    localparam logic [YW-1:0] Y_MAX  = '1;
    localparam logic [PW-1:0] C_R    = PW'(77);
    localparam logic [PW-1:0] C_G    = PW'(150);
    localparam logic [PW-1:0] C_B    = PW'(29);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic sof;
        logic sol;
        logic eol;
        logic eof;
        logic done;
    } flags_t;

    state_t          state;
    logic [XW-1:0]   x, px;
    logic [YW-1:0]   y, py;
    logic            start, accept;
    logic [2:0]      err_new;
    flags_t          flg_in, flg1;
    logic [STAGES:1] vld_pipe;
    logic [PW-1:0]   pr, pg, pb;
    logic [PW:0]     sum;
    logic            sum_unused;

    // A sof beat always sits at (0,0); every other accepted beat sits at the current counters.
    assign start  = pix_val & pix_sof;
    assign accept = pix_val & ((state == ACTIVE) | pix_sof);
    assign px     = start ? '0 : x;
    assign py     = start ? '0 : y;

    always_comb begin
        err_new = '0;
        if (accept) begin
            err_new[0] = pix_eol != (px == X_LAST);
            err_new[1] = pix_eof & ~((px == X_LAST) & (py == Y_LAST));
            err_new[2] = start & (state == ACTIVE);
        end
    end

`ifdef RGB2GRAY_FRAMING_REGEN_EN
    logic sol_unused;
    assign sol_unused = pix_sol;
    always_comb begin
        flg_in      = '0;
        flg_in.sof  = start;
        flg_in.sol  = px == '0;
        flg_in.eol  = px == X_LAST;
        flg_in.eof  = (px == X_LAST) & (py == Y_LAST);
        flg_in.done = pix_eof;
    end
`else
    always_comb begin
        flg_in      = '0;
        flg_in.sof  = pix_sof;
        flg_in.sol  = pix_sol;
        flg_in.eol  = pix_eol;
        flg_in.eof  = pix_eof;
        flg_in.done = pix_eof;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            err_status <= '0;
        end else begin
            err_status <= (err_clr ? 3'b000 : err_status) | err_new;
            if (accept) begin
                if (pix_eof) begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                end else if (pix_eol) begin
                    state <= ACTIVE;
                    x     <= '0;
                    y     <= (py == Y_MAX) ? py : py + YW'(1);
                end else begin
                    // An overlong line parks x on the last column until eol arrives.
                    state <= ACTIVE;
                    x     <= (px == X_LAST) ? px : px + XW'(1);
                    y     <= py;
                end
            end
        end
    end

    assign sum        = {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + (PW+1)'(128);
    assign sum_unused = ^{sum[PW], sum[CW-1:0]};
    assign gray_val   = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_pipe   <= '0;
            pr         <= '0;
            pg         <= '0;
            pb         <= '0;
            flg1       <= '0;
            gray_data  <= '0;
            gray_sof   <= 1'b0;
            gray_sol   <= 1'b0;
            gray_eol   <= 1'b0;
            gray_eof   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept) begin
                pr   <= C_R * PW'(pix_data[3*CW-1 -: CW]);
                pg   <= C_G * PW'(pix_data[2*CW-1 -: CW]);
                pb   <= C_B * PW'(pix_data[CW-1:0]);
                flg1 <= flg_in;
            end
            if (vld_pipe[1])
                gray_data <= sum[CW +: CW];
            gray_sof   <= vld_pipe[1] & flg1.sof;
            gray_sol   <= vld_pipe[1] & flg1.sol;
            gray_eol   <= vld_pipe[1] & flg1.eol;
            gray_eof   <= vld_pipe[1] & flg1.eof;
            frame_done <= vld_pipe[1] & flg1.done;
        end
    end
endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Randomized and directed bench for rgb_to_gray_stream against a pixel-level framing model.
module tb_rgb_to_gray_stream;
    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pix_val = 1'b0, pix_sof = 1'b0, pix_eof = 1'b0, pix_sol = 1'b0, pix_eol = 1'b0;
    logic [23:0] pix_data = '0;
    logic        err_clr = 1'b0;
    logic        gray_val, gray_sof, gray_eof, gray_sol, gray_eol, frame_done;
    logic [7:0]  gray_data;
    logic [2:0]  err_status;

    always #5 clk = ~clk;

    rgb_to_gray_stream #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIX_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_val(pix_val), .pix_sof(pix_sof), .pix_eof(pix_eof),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_data(pix_data),
        .gray_val(gray_val), .gray_sof(gray_sof), .gray_eof(gray_eof),
        .gray_sol(gray_sol), .gray_eol(gray_eol), .gray_data(gray_data),
        .frame_done(frame_done), .err_clr(err_clr), .err_status(err_status)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
        logic [4:0] flg;   // {sof, sol, eol, eof, done}
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         out_beats = 0;
    exp_t       q[$];
    bit         in_frame = 0;
    int         col = 0, row = 0;
    logic [2:0] m_err = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] luma(input logic [23:0] rgb);
        int s;
        s = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]) + 128;
        return 8'(s / 256);
    endfunction

    // Reference: a frame opens on sof, pixels are placed by (col,row), errors follow the framing rules.
    task automatic model(input bit v, sof, sol, eol, eof, input logic [23:0] d, input bit clr);
        logic [2:0] nerr;
        exp_t       e;
        int         c, r;
        nerr = '0;
        if (v && (in_frame || sof)) begin
            c = sof ? 0 : col;
            r = sof ? 0 : row;
            if (eol != (c == W-1)) nerr[0] = 1'b1;
            if (eof && !(c == W-1 && r == H-1)) nerr[1] = 1'b1;
            if (sof && in_frame) nerr[2] = 1'b1;
            e.due = cyc + 2;
            e.d   = luma(d);
`ifdef RGB2GRAY_FRAMING_REGEN_EN
            e.flg = {sof, c == 0, c == W-1, (c == W-1) && (r == H-1), eof};
`else
            e.flg = {sof, sol, eol, eof, eof};
`endif
            q.push_back(e);
            if (eof) begin
                in_frame = 0; col = 0; row = 0;
            end else begin
                in_frame = 1;
                if (eol) begin col = 0; row = r + 1; end
                else begin col = (c + 1 > W-1) ? W-1 : c + 1; row = r; end
            end
        end
        m_err = (clr ? 3'b000 : m_err) | nerr;
    endtask

    task automatic step(input bit v, sof, sol, eol, eof, input logic [23:0] d,
                        input bit clr = 0, input bit rst = 0);
        exp_t e;
        pix_val = v; pix_sof = sof; pix_sol = sol; pix_eol = eol; pix_eof = eof;
        pix_data = d; err_clr = clr; rst_n = rst;
        if (rst) begin
            q.delete(); in_frame = 0; col = 0; row = 0; m_err = '0;
        end else begin
            model(v, sof, sol, eol, eof, d, clr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (gray_val) out_beats++;
        if (rst) begin
            chk("rst_out", {gray_val, gray_sof, gray_sol, gray_eol, gray_eof, frame_done, gray_data},
                '0);
            chk("rst_err", err_status, 3'b000);
        end else begin
            chk("err", err_status, m_err);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("val", gray_val, 1'b1);
                chk("data", gray_data, e.d);
                chk("flags", {gray_sof, gray_sol, gray_eol, gray_eof, frame_done}, e.flg);
            end else begin
                chk("idle", {gray_val, gray_sof, gray_sol, gray_eol, gray_eof, frame_done}, '0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 24'h0);
    endtask

    task automatic send_frame(input int lines = H);
        for (int r = 0; r < lines; r++)
            for (int c = 0; c < W; c++)
                step(1, r == 0 && c == 0, c == 0, c == W-1, r == H-1 && c == W-1, 24'($urandom));
    endtask

    int  base;
    bit  s, l, e, o;
    logic [23:0] rgb_tab[5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h646464};
    logic [7:0]  gray_tab[5] = '{8'd255, 8'd77, 8'd149, 8'd29, 8'd100};

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Single pixels, each in a fresh frame after reset.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            step(1, 1, 1, 0, 0, rgb_tab[i]);
            chk("lat1", gray_val, 1'b0);
            step(0, 0, 0, 0, 0, 0);
            chk("lat2", gray_val, 1'b1);
            chk("const_gray", gray_data, gray_tab[i]);
        end

        // Well-formed frame.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        base = out_beats;
        send_frame();
        idle(3);
        chk("frame_beats", out_beats - base, 12);
        chk("frame_err", err_status, 3'b000);

        // Orphan beats in IDLE, then a valid frame.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        base = out_beats;
        for (int i = 0; i < 5; i++) step(1, 0, i == 0, 0, 0, 24'($urandom));
        chk("orphan_beats", out_beats - base, 0);
        send_frame();
        idle(3);
        chk("orphan_frame_beats", out_beats - base, 12);
        chk("orphan_err", err_status, 3'b000);

        // Short line.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 24'h123456);
        step(1, 0, 0, 0, 0, 24'h654321);
        step(1, 0, 0, 1, 0, 24'hABCDEF);
        idle(4);
        chk("line_err_held", err_status, 3'b001);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("line_err_clr", err_status, 3'b000);

        // sof in the middle of line 1.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        send_frame(1);
        step(1, 0, 1, 0, 0, 24'h111111);
        step(1, 0, 0, 0, 0, 24'h222222);
        step(1, 1, 0, 0, 0, 24'h333333);
        chk("midsof_err", err_status, 3'b100);
        step(0, 0, 0, 0, 0, 0);
        chk("midsof_out", {gray_val, gray_sof}, 2'b11);

        // Early eof at (2,1).
        step(0, 0, 0, 0, 0, 0, 0, 1);
        send_frame(1);
        step(1, 0, 1, 0, 0, 24'h444444);
        step(1, 0, 0, 0, 0, 24'h555555);
        step(1, 0, 0, 0, 1, 24'h666666);
        chk("eof_err", err_status, 3'b010);
        step(1, 0, 0, 0, 0, 24'h777777);
        chk("eof_done", {gray_val, frame_done}, 2'b11);
        step(0, 0, 0, 0, 0, 0);
        chk("eof_idle", gray_val, 1'b0);

        // Reset one cycle after a valid beat.
        step(1, 1, 1, 0, 0, 24'h808080);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_drop", gray_val, 1'b0);

        // Randomized frames with occasional flag corruption, gaps, clears and resets.
        for (int f = 0; f < 150; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    while ($urandom_range(0, 9) == 0) step(0, 0, 0, 0, 0, 24'($urandom),
                                                         $urandom_range(0, 19) == 0);
                    s = (r == 0 && c == 0) ^ ($urandom_range(0, 29) == 0);
                    l = (c == 0) ^ ($urandom_range(0, 29) == 0);
                    e = (c == W-1) ^ ($urandom_range(0, 29) == 0);
                    o = (r == H-1 && c == W-1) ^ ($urandom_range(0, 29) == 0);
                    step(1, s, l, e, o, 24'($urandom), $urandom_range(0, 19) == 0,
                         $urandom_range(0, 199) == 0);
                end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
